sm4_key_rev: RTL

Word-serial SM4 inverse key schedule for the decryption path. It is loaded with the final key-schedule state {K32,K33,K34,K35}, which the forward key register leaves behind after round 31. It then emits round keys in decryption order, rk31 down to rk0, over a valid/ready stream. At the end it recovers the master key MK. The round transform T' (tau + L') sits outside the block, on the rt_in/rt_out pair, as it does on the forward side.

---
 rtl/sm4_key_rev.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sm4_key_rev.sv
`default_nettype none
// ============================================================================
// Module   : sm4_key_rev
// Purpose  : Word-serial SM4 inverse key schedule. Loaded with the final
//            key-schedule state {K32,K33,K34,K35}, it emits round keys rk31
//            down to rk0 over a valid/ready stream, then presents the
//            recovered master key. The T' transform (tau + L') is external,
//            reached through the rt_in/rt_out pair.
// Ports    : clk, rst_n         - clock, async active-low reset
//            load, key_in       - start request and {K32,K33,K34,K35}
//            rt_in, rt_out      - operand to / result from external T'
//            rk_out, rk_idx     - current round key and its index
//            rk_valid, rk_ready - round-key stream handshake
//            busy               - key stream in progress
//            mk_out, mk_valid   - recovered master key {MK0..MK3}
// Revision : 1.0 - initial release
// ============================================================================
module sm4_key_rev (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] key_in,
  output logic [31:0]  rt_in,
  input  logic [31:0]  rt_out,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic [127:0] mk_out,
  output logic         mk_valid
);

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] r0_q, r1_q, r2_q, r3_q;
  logic [31:0] r0_d, r1_d, r2_d, r3_d;
  logic [4:0]  idx_q, idx_d;
  logic        rk_valid_q, rk_valid_d;
  logic        busy_q, busy_d;
  logic        mk_valid_q, mk_valid_d;

  logic [7:0]  idx8;
  logic [7:0]  ck_b0;
  logic [31:0] ck;

  // CK byte j = 28*i + 7*j, all arithmetic wrapping at 8 bits.
  always_comb begin
    idx8  = {3'b000, idx_q};
    ck_b0 = idx8 * 8'd28;
    ck    = {ck_b0, ck_b0 + 8'd7, ck_b0 + 8'd14, ck_b0 + 8'd21};
  end

  // r0..r2 hold K_{i+1..i+3}; T' of their XOR with CK_i recovers K_i from K_{i+4}.
  assign rt_in    = r0_q ^ r1_q ^ r2_q ^ ck;
  assign rk_out   = r3_q;
  assign rk_idx   = idx_q;
  assign rk_valid = rk_valid_q;
  assign busy     = busy_q;
  assign mk_valid = mk_valid_q;
  assign mk_out   = {r0_q ^ FK0, r1_q ^ FK1, r2_q ^ FK2, r3_q ^ FK3};

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          r0_d    = key_in[127:96];
          r1_d    = key_in[95:64];
          r2_d    = key_in[63:32];
          r3_d    = key_in[31:0];
          idx_d   = 5'd31;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rk_valid_q && rk_ready) begin
          r0_d = r3_q ^ rt_out;
          r1_d = r0_q;
          r2_d = r1_q;
          r3_d = r2_q;
          // Last key leaves DONE holding {K0..K3}; idx does not wrap.
          if (idx_q == 5'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    rk_valid_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN);
    mk_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r0_q       <= 32'd0;
      r1_q       <= 32'd0;
      r2_q       <= 32'd0;
      r3_q       <= 32'd0;
      idx_q      <= 5'd31;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      mk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      mk_valid_q <= mk_valid_d;
    end
  end

endmodule
`default_nettype wire
